// File: rtl/cic_interp.sv
// cic_interp: N-stage CIC interpolator (comb at input rate, zero-stuff by RATE,
// pipelined integrators at output rate, arithmetic-shift output scaling).
// Valid/ready handshake on both sides; back-pressure stalls the integrators.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_data    signed input sample (IN_W)
//   in_valid   input sample present
//   in_ready   filter accepts in_data this cycle (combinational)
//   out_data   signed interpolated sample (OUT_W), registered
//   out_valid  out_data valid, registered
//   out_ready  downstream consumes out_data this cycle
//
// Build option: define CIC_ROUND_EN to round half up before the output shift
// (no effect when ACC_W == OUT_W). Default build truncates.
//
// Parameter constraints: N_STAGES >= 1, RATE >= 2, DIFF_DELAY in {1,2},
// OUT_W <= ACC_W.
module cic_interp #(
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned N_STAGES   = 4,
    parameter int unsigned RATE       = 8,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned ACC_W = IN_W + N_STAGES * $clog2(RATE * DIFF_DELAY);
    localparam int unsigned SHIFT = ACC_W - OUT_W;
    localparam int unsigned PH_W  = $clog2(RATE);

    typedef logic signed [ACC_W-1:0] acc_t;

`ifdef CIC_ROUND_EN
    // Half-LSB of the output grid; zero when no bits are dropped.
    localparam acc_t RND = (SHIFT > 0) ? (acc_t'(1) << (SHIFT - 1)) : acc_t'(0);
`else
    localparam acc_t RND = acc_t'(0);
`endif

    acc_t                    comb_in  [N_STAGES];
    acc_t                    comb_out;
    acc_t                    dly_q    [N_STAGES][DIFF_DELAY];
    acc_t                    dly_d    [N_STAGES][DIFF_DELAY];
    acc_t                    integ_q  [N_STAGES];
    acc_t                    integ_d  [N_STAGES];
    acc_t                    hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    phase_zero;
    logic                    adv;
    logic                    accept;
    acc_t                    upsamp;
    acc_t                    scaled;

    // Comb chain: a running temporary keeps the chain free of array self-loops.
    always_comb begin
        acc_t c;
        c = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
        for (int k = 0; k < int'(N_STAGES); k++) begin
            comb_in[k] = c;
            c          = c - dly_q[k][DIFF_DELAY-1];
        end
        comb_out = c;
    end

    // Handshake, upsampler, integrators and output register next-state.
    always_comb begin
        dly_d        = dly_q;
        integ_d      = integ_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        phase_d      = phase_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;

        phase_zero = (phase_q == '0);
        adv        = (!out_valid_q || out_ready) && (!phase_zero || hold_valid_q);
        // A consume at phase 0 frees hold in the same cycle, allowing full rate.
        in_ready   = !rst && (!hold_valid_q || (adv && phase_zero));
        accept     = in_valid && in_ready;
        upsamp     = phase_zero ? hold_q : acc_t'(0);
        scaled     = (integ_q[N_STAGES-1] + RND) >>> SHIFT;

        if (accept) begin
            for (int k = 0; k < int'(N_STAGES); k++) begin
                dly_d[k][0] = comb_in[k];
                for (int d = 1; d < int'(DIFF_DELAY); d++) begin
                    dly_d[k][d] = dly_q[k][d-1];
                end
            end
        end

        if (adv) begin
            // Each stage adds the previous stage's pre-edge value (one cycle per stage).
            integ_d[0] = integ_q[0] + upsamp;
            for (int k = 1; k < int'(N_STAGES); k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            out_data_d  = scaled[OUT_W-1:0];
            out_valid_d = 1'b1;
            phase_d     = (phase_q == PH_W'(RATE - 1)) ? '0 : phase_q + PH_W'(1);
            if (phase_zero) begin
                hold_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            hold_d       = comb_out;
            hold_valid_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N_STAGES); k++) begin
                integ_q[k] <= '0;
                for (int d = 0; d < int'(DIFF_DELAY); d++) begin
                    dly_q[k][d] <= '0;
                end
            end
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            phase_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            dly_q        <= dly_d;
            integ_q      <= integ_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            phase_q      <= phase_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interp.sv
// tb_cic_interp: self-checking bench for cic_interp (N=2, R=4, M=1, IN_W=8).
// Instance A: OUT_W=12 (no shift); instance B: OUT_W=10 (shift by 2).
// Hand-written vector table for the directed patterns, plus randomized traffic
// checked against an impulse-response (convolution) model of the filter.
module tb_cic_interp;

    localparam int IN_W  = 8;
    localparam int NS    = 2;
    localparam int R     = 4;
    localparam int M     = 1;
    localparam int OUT_A = 12;
    localparam int OUT_B = 10;
    localparam int ACC_W = IN_W + NS * 2;
    localparam int HLEN  = NS * (R * M - 1) + 1;

`ifdef CIC_ROUND_EN
    localparam int IMP_B = 1;
    localparam int RND_B = 2;
`else
    localparam int IMP_B = 0;
    localparam int RND_B = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    out_ready;
    logic                    in_ready_a, in_ready_b;
    logic                    out_valid_a, out_valid_b;
    logic signed [OUT_A-1:0] out_data_a;
    logic signed [OUT_B-1:0] out_data_b;

    always #5 clk = ~clk;

    cic_interp #(.IN_W(IN_W), .OUT_W(OUT_A), .N_STAGES(NS), .RATE(R), .DIFF_DELAY(M)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    cic_interp #(.IN_W(IN_W), .OUT_W(OUT_B), .N_STAGES(NS), .RATE(R), .DIFF_DELAY(M)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    typedef struct {
        int x0;
        int xn;
        int exp_a[10];
        int b_idx;
        int b_exp;
    } vec_t;

    vec_t rows[4];
    int   errors = 0;
    int   checks = 0;
    int   acc_q[$];
    int   out_a[$];
    int   out_b[$];
    int   h[HLEN];
    int   pa[HLEN];
    int   pb[HLEN];
    bit   prev_stall;
    int   prev_data;
    bit   last_acc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wrap(input longint v, input int w);
        longint m = longint'(1) << w;
        longint r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    // Output j = sum_k h[k] * up[j - NS - k]; up is the zero-stuffed accepted input.
    function automatic int model_a(input int j);
        longint s = 0;
        for (int k = 0; k < HLEN; k++) begin
            int i = j - NS - k;
            if (i >= 0 && (i % R) == 0 && (i / R) < acc_q.size())
                s += longint'(h[k]) * longint'(acc_q[i / R]);
        end
        return wrap(s, ACC_W);
    endfunction

    function automatic int scale_b(input int v);
        int t = wrap(longint'(v + RND_B), ACC_W);
        int f = (t >= 0) ? t / 4 : -((-t + 3) / 4);
        return wrap(longint'(f), OUT_B);
    endfunction

    // Observe handshakes for the cycle whose inputs are currently applied.
    task automatic sample();
        int j;
        int ea;
        last_acc = in_valid && in_ready_a;
        if (prev_stall) begin
            check("bp_valid", int'(out_valid_a), 1);
            check("bp_data", int'(out_data_a), prev_data);
        end
        if (out_valid_a && out_ready) begin
            j  = out_a.size();
            ea = model_a(j);
            check("model_a", int'(out_data_a), ea);
            check("valid_b", int'(out_valid_b), 1);
            check("model_b", int'(out_data_b), scale_b(ea));
            out_a.push_back(int'(out_data_a));
            out_b.push_back(int'(out_data_b));
        end
        prev_stall = out_valid_a && !out_ready;
        prev_data  = int'(out_data_a);
        if (last_acc) acc_q.push_back(int'(in_data));
    endtask

    task automatic step(input bit v, input int d, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_data   = IN_W'(d);
        out_ready = r;
        #1;
        sample();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready_a), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_data", int'(out_data_a), 0);
        check("rst_out_valid_b", int'(out_valid_b), 0);
        acc_q.delete();
        out_a.delete();
        out_b.delete();
        prev_stall = 1'b0;
    endtask

    task automatic run_row(input int idx);
        int rdy_cnt;
        do_reset();
        rdy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, (acc_q.size() == 0) ? rows[idx].x0 : rows[idx].xn, 1'b1);
            if (c >= 8 && in_ready_a) rdy_cnt++;
        end
        check("in_ready_rate", rdy_cnt, 8);
        if (out_a.size() < 10) begin
            check("row_len", out_a.size(), 10);
        end else begin
            for (int i = 0; i < 10; i++) check($sformatf("row%0d_out%0d", idx, i), out_a[i], rows[idx].exp_a[i]);
            check($sformatf("row%0d_b", idx), out_b[rows[idx].b_idx], rows[idx].b_exp);
        end
    endtask

    initial begin
        bit have;
        int cur;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Impulse response of the whole filter: (1 + z^-1 + ... + z^-(RM-1))^N.
        pa = '{default: 0};
        pa[0] = 1;
        for (int s = 0; s < NS; s++) begin
            pb = '{default: 0};
            for (int n = 0; n < HLEN; n++)
                for (int i = 0; i < R * M; i++)
                    if (n - i >= 0) pb[n] += pa[n - i];
            pa = pb;
        end
        h = pa;

        rows[0] = '{5, 5, '{0, 0, 5, 10, 15, 20, 20, 20, 20, 20}, 9, 5};
        rows[1] = '{1, 0, '{0, 0, 1, 2, 3, 4, 3, 2, 1, 0}, 3, IMP_B};
        rows[2] = '{-3, -3, '{0, 0, -3, -6, -9, -12, -12, -12, -12, -12}, 9, -3};
        rows[3] = '{3, 3, '{0, 0, 3, 6, 9, 12, 12, 12, 12, 12}, 9, 3};

        for (int idx = 0; idx < 4; idx++) run_row(idx);

        // Random traffic with input gaps, random back-pressure and a mid-stream reset.
        do_reset();
        have = 1'b0;
        cur  = 0;
        for (int c = 0; c < 1600; c++) begin
            bit gap;
            bit r;
            if (c == 800) begin
                do_reset();
                continue;
            end
            gap = ((c % 100) >= 40) && ((c % 100) < 56);
            if (!have && !gap && $urandom_range(0, 3) != 0) begin
                cur  = int'($urandom_range(0, 255)) - 128;
                have = 1'b1;
            end
            r = gap ? 1'b1 : ($urandom_range(0, 1) == 1);
            step(have && !gap, cur, r);
            if (last_acc) have = 1'b0;
            if ((c % 100) == 55) check("starve_valid", int'(out_valid_a), 0);
        end
        for (int c = 0; c < 20; c++) step(1'b0, 0, 1'b1);
        check("rate", out_a.size(), R * acc_q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
